// File: rtl/servo_pulse_capture_if.sv
// Signal bundle between the servo pulse decoder and its consumer.
// The master side is the decoder; the slave side drives enable and the pin.
interface servo_pulse_capture_if;
  logic        en;
  logic        pwm_in;
  logic [15:0] data;
  logic        data_valid;
  logic        range_err;
  logic        signal_lost;

  modport master (
    input  en,
    input  pwm_in,
    output data,
    output data_valid,
    output range_err,
    output signal_lost
  );

  modport slave (
    output en,
    output pwm_in,
    input  data,
    input  data_valid,
    input  range_err,
    input  signal_lost
  );
endinterface

// File: rtl/servo_pulse_capture.sv
// Servo pulse decoder: measures pulse high time and divides it back to a 0..POS_MAX code.
// Optional frame-period qualification is enabled by defining SERVO_CAPTURE_PERIOD_CHECK_EN.
module servo_pulse_capture #(
  parameter int MIN_PULSE      = 75_000,
  parameter int MAX_PULSE      = 150_000,
  parameter int TOL            = 1_000,
  parameter int POS_MAX        = 100,
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int PERIOD_CYCLES  = 1_000_000,
  parameter int PER_TOL        = 50_000
) (
  input logic                   clk,
  input logic                   rst,
  servo_pulse_capture_if.master bus
);
  localparam int CW = $clog2(MAX_PULSE + TOL + 2);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [CW-1:0] LIMIT_C   = CW'(MAX_PULSE + TOL + 1);
  localparam logic [CW-1:0] REJ_LO_C  = CW'(MIN_PULSE - TOL);
  localparam logic [CW-1:0] MIN_C     = CW'(MIN_PULSE);
  localparam logic [CW-1:0] MAX_C     = CW'(MAX_PULSE);
  localparam logic [CW-1:0] MAXTOL_C  = CW'(MAX_PULSE + TOL);
  localparam logic [TW-1:0] TMAX_C    = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TONE_C    = TW'(1);
  localparam logic [31:0]   POS_W     = 32'(POS_MAX);
  localparam logic [31:0]   DSH_INIT  = 32'(MAX_PULSE - MIN_PULSE) << 7;
  localparam logic [1:0]    CLS_NORM  = 2'd0;
  localparam logic [1:0]    CLS_LO    = 2'd1;
  localparam logic [1:0]    CLS_HI    = 2'd2;
  localparam logic [1:0]    CLS_REJ   = 2'd3;

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, SKIP = 2'd2, DIV = 2'd3} state_t;

  state_t        state_r, state_nxt_s;
  logic          sync1_r, sync2_r, prev_r;
  logic [1:0]    fill_r;
  logic          rise_s, fall_s, armed_s;
  logic          load_s, inc_s, latch_s, over_s, step_s, done_s;
  logic [CW-1:0] cnt_r, diff_s;
  logic [1:0]    cls_r, cls_s;
  logic [23:0]   rem_r, num_s;
  logic [31:0]   dsh_r;
  logic [6:0]    quo_r;
  logic [2:0]    step_r;
  logic          qbit_s;
  logic [15:0]   data_r;
  logic          data_valid_r, range_err_r, lost_r;
  logic [TW-1:0] tcnt_r, tcnt_nxt_s;

  // Edge detection is armed only once prev_r holds a real sample, so a level high at reset exit is not an edge.
  assign armed_s = (fill_r == 2'd3);
  assign rise_s  = armed_s & sync2_r & ~prev_r;
  assign fall_s  = armed_s & ~sync2_r & prev_r;
  assign qbit_s  = ({8'd0, rem_r} >= dsh_r);
  assign diff_s  = cnt_r - MIN_C;
  assign num_s   = 24'({{(32-CW){1'b0}}, diff_s} * POS_W);

`ifdef SERVO_CAPTURE_PERIOD_CHECK_EN
  localparam logic [20:0] PLO_C = 21'(PERIOD_CYCLES - PER_TOL);
  localparam logic [20:0] PHI_C = 21'(PERIOD_CYCLES + PER_TOL);
  logic [20:0] per_r;
  logic        per_seen_r, per_ok_r;

  // Rising-edge to rising-edge period; the first pulse after en, reset or loss has no valid period.
  always_ff @(posedge clk) begin
    if (rst) begin
      per_r      <= 21'd0;
      per_seen_r <= 1'b0;
      per_ok_r   <= 1'b0;
    end else begin
      if (rise_s) begin
        per_r    <= 21'd1;
        per_ok_r <= per_seen_r && (per_r >= PLO_C) && (per_r <= PHI_C);
      end else if (per_r != 21'h1F_FFFF) begin
        per_r <= per_r + 21'd1;
      end
      if (!bus.en || (tcnt_nxt_s == TMAX_C)) begin
        per_seen_r <= 1'b0;
      end else if (rise_s) begin
        per_seen_r <= 1'b1;
      end
    end
  end
`endif

  // Width classification of the just-finished pulse.
  always_comb begin
    cls_s = CLS_NORM;
    if ((cnt_r < REJ_LO_C) || (cnt_r > MAXTOL_C)) begin
      cls_s = CLS_REJ;
    end else if (cnt_r < MIN_C) begin
      cls_s = CLS_LO;
    end else if (cnt_r > MAX_C) begin
      cls_s = CLS_HI;
    end else begin
      cls_s = CLS_NORM;
    end
`ifdef SERVO_CAPTURE_PERIOD_CHECK_EN
    if (!per_ok_r) begin
      cls_s = CLS_REJ;
    end else begin
      cls_s = cls_s;
    end
`endif
  end

  // Next-state and control strobes.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    inc_s       = 1'b0;
    latch_s     = 1'b0;
    over_s      = 1'b0;
    step_s      = 1'b0;
    done_s      = 1'b0;
    if (!bus.en) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            load_s      = 1'b1;
            state_nxt_s = HIGH;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        HIGH: begin
          if (!sync2_r) begin
            latch_s     = 1'b1;
            state_nxt_s = DIV;
          end else if (cnt_r == LIMIT_C) begin
            over_s      = 1'b1;
            state_nxt_s = SKIP;
          end else begin
            inc_s       = 1'b1;
            state_nxt_s = HIGH;
          end
        end
        SKIP: begin
          if (fall_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = SKIP;
          end
        end
        DIV: begin
          step_s = 1'b1;
          if (step_r == 3'd7) begin
            done_s      = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = DIV;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Timeout counter: cleared by each rising edge, saturating otherwise.
  always_comb begin
    if (rise_s) begin
      tcnt_nxt_s = '0;
    end else if (tcnt_r == TMAX_C) begin
      tcnt_nxt_s = tcnt_r;
    end else begin
      tcnt_nxt_s = tcnt_r + TONE_C;
    end
  end

  // Synchronizer, FSM state and pulse-width measurement.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      prev_r  <= 1'b0;
      fill_r  <= 2'd0;
      state_r <= IDLE;
      cnt_r   <= '0;
      tcnt_r  <= '0;
    end else begin
      sync1_r <= bus.pwm_in;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
      if (fill_r != 2'd3) begin
        fill_r <= fill_r + 2'd1;
      end
      state_r <= state_nxt_s;
      tcnt_r  <= tcnt_nxt_s;
      if (load_s) begin
        cnt_r <= ONE_C;
      end else if (inc_s) begin
        cnt_r <= cnt_r + ONE_C;
      end
    end
  end

  // Restoring divider: one quotient bit per cycle, MSB first, divisor pre-shifted by 7.
  always_ff @(posedge clk) begin
    if (rst) begin
      cls_r  <= CLS_NORM;
      rem_r  <= 24'd0;
      dsh_r  <= 32'd0;
      quo_r  <= 7'd0;
      step_r <= 3'd0;
    end else if (latch_s) begin
      cls_r  <= cls_s;
      rem_r  <= (cls_s == CLS_NORM) ? num_s : 24'd0;
      dsh_r  <= DSH_INIT;
      quo_r  <= 7'd0;
      step_r <= 3'd0;
    end else if (step_s) begin
      rem_r  <= qbit_s ? (rem_r - dsh_r[23:0]) : rem_r;
      dsh_r  <= dsh_r >> 1;
      quo_r  <= {quo_r[5:0], qbit_s};
      step_r <= step_r + 3'd1;
    end
  end

  // Registered outputs and loss-of-signal flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r       <= 16'd0;
      data_valid_r <= 1'b0;
      range_err_r  <= 1'b0;
      lost_r       <= 1'b0;
    end else begin
      data_valid_r <= 1'b0;
      range_err_r  <= 1'b0;
      if (over_s || (done_s && (cls_r == CLS_REJ))) begin
        range_err_r <= 1'b1;
      end else if (done_s) begin
        data_valid_r <= 1'b1;
        case (cls_r)
          CLS_LO:  data_r <= 16'd0;
          CLS_HI:  data_r <= 16'(POS_MAX);
          default: data_r <= {8'd0, quo_r, qbit_s};
        endcase
      end
      if (done_s && (cls_r != CLS_REJ)) begin
        lost_r <= 1'b0;
      end else if (tcnt_nxt_s == TMAX_C) begin
        lost_r <= 1'b1;
      end
    end
  end

  assign bus.data        = data_r;
  assign bus.data_valid  = data_valid_r;
  assign bus.range_err   = range_err_r;
  assign bus.signal_lost = lost_r;
endmodule
